mem_sp_bytewr: RTL and testbench
================================

// Module: mem_sp_bytewr
// PURPOSE
//  Parametrised single-port synchronous RAM, successor to the basic en/wr/addr memory.
//  Adds per-byte write enables, configurable read latency, out-of-range address detection and self-clearing after reset.
//  Sits behind the memory bus as the DUT of the memory UVM environment.
// PARAMETERS
//  ADDR_WIDTH  32   request address width; only the low $clog2(DEPTH) bits index the array.
//  DATA_WIDTH  32   word width; must be a multiple of 8.
//  DEPTH       256  number of words, 2..65536; need not be a power of 2.
//  RD_LATENCY  1    cycles from read accept to valid_out, 1..4.
// PORTS
//  clk        in   1             single clock, rising edge.
//  rst        in   1             synchronous, active-high reset.
//  en         in   1             request strobe.
//  wr         in   1             1 = write, 0 = read; sampled with en.
//  addr       in   ADDR_WIDTH    word address.
//  be         in   DATA_WIDTH/8  byte-lane write enables; ignored on reads.
//  data_in    in   DATA_WIDTH    write data.
//  ready      out  1             0 while clearing; requests are accepted only when en && ready.
//  data_out   out  DATA_WIDTH    read data; valid only while valid_out = 1.
//  valid_out  out  1             one-cycle pulse per accepted read.
//  addr_err   out  1             one-cycle pulse, RD_LATENCY after an accepted out-of-range request.
// BEHAVIOUR
//  Reset (rst = 1 at a clk edge): ready=0, valid_out=0, addr_err=0, data_out=0; read pipeline flushed; FSM -> ST_CLEAR, clear pointer=0.
//  FSM ST_CLEAR:
//   - writes 0 to word[ptr] each cycle; ptr++.
//   - ptr == DEPTH-1 -> ST_READY at the next edge; ready=1 from then on.
//   - clear takes exactly DEPTH cycles after rst deasserts.
//   - en is ignored; no valid_out or addr_err is generated.
//  FSM ST_READY: stays there until rst.
//  Accepted write:
//   - for each lane i with be[i]=1: word[addr][8i+7:8i] <= data_in lane i.
//   - be=0 is a legal no-op.
//   - no response output.
//  Accepted read:
//   - word[addr] appears on data_out with valid_out=1 exactly RD_LATENCY cycles later.
//   - back-to-back reads give back-to-back valid pulses in order; throughput 1/cycle.
//  Ordering: a read accepted the cycle after a write to the same address returns the new data; no hazard stall.
//  Out of range (addr >= DEPTH, including any nonzero upper bit):
//   - write: array unchanged.
//   - read: data_out=0 with valid_out=1.
//   - both: addr_err=1 in the same cycle valid_out would rise.
//  data_out holds its last value when valid_out=0.
//  Reset mid-read: in-flight reads are discarded; valid_out is 0 from the cycle after the reset edge. Reset mid-clear restarts ptr at 0.
// CONFIGURATION
//  MEM_PARITY_EN defined:
//   - each stored byte carries an even-parity bit, written with the lane.
//   - output parity_err (1 bit) pulses with valid_out on any lane mismatch.
//   - input inj_par (1) flips stored parity on accepted writes, for test.
//  MEM_PARITY_EN undefined: no parity storage, no parity_err/inj_par ports, all else identical.
// STRUCTURE
//  Package mem_pkg:
//   - typedef enum logic {ST_CLEAR, ST_READY} mem_state_t.
//   - localparam MAX_RD_LATENCY = 4.
//   - function in_range(addr, depth).
//  Sub-module mem_rd_pipe:
//   - RD_LATENCY-stage shift of {valid, err, data[, perr]} with synchronous flush on rst.
//  Top level: clear FSM, storage array, byte-merge write logic.
// TESTING
//  1. rst 1 cycle, DEPTH=256 -> ready=0 for 256 cycles, then 1; a read of any address returns 0.
//  2. Write 0xDEADBEEF be=4'hF to addr 5; read 5 -> data_out=0xDEADBEEF exactly RD_LATENCY cycles later.
//  3. Write be=4'b0101 data=0x11223344 over 0xDEADBEEF -> read returns 0xDE22BE44.
//  4. Reads of addr 0..7, back to back, RD_LATENCY=3 -> 8 consecutive valid_out pulses with data in order.
//  5. Read addr=DEPTH, and addr=0x8000_0000 -> data_out=0, valid_out=1, addr_err=1; a write there leaves word 0 unchanged.
//  6. rst while 2 reads in flight -> no valid_out afterwards; clear restarts, and ready is low for DEPTH cycles.

Source files
------------

// File: rtl/mem_sp_bytewr_pkg.sv
// Shared types and helpers for the byte-writable single-port RAM.
package mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_t;

  localparam int unsigned MAX_RD_LATENCY = 4;

  // True when a (zero-extended) request address indexes an existing word.
  function automatic logic in_range(input logic [63:0] addr, input int unsigned depth);
    return addr < 64'(depth);
  endfunction

endpackage

// File: rtl/mem_sp_bytewr_if.sv
// Request/response bus of the byte-writable RAM.
// MEM_PARITY_EN adds inj_par (request side) and parity_err (response side).
interface mem_sp_bytewr_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;

  logic                  en;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [NUM_LANES-1:0]  be;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  addr_err;
`ifdef MEM_PARITY_EN
  logic                  inj_par;
  logic                  parity_err;

  modport master (
    output en, wr, addr, be, data_in, inj_par,
    input  ready, data_out, valid_out, addr_err, parity_err
  );

  modport slave (
    input  en, wr, addr, be, data_in, inj_par,
    output ready, data_out, valid_out, addr_err, parity_err
  );
`else
  modport master (
    output en, wr, addr, be, data_in,
    input  ready, data_out, valid_out, addr_err
  );

  modport slave (
    input  en, wr, addr, be, data_in,
    output ready, data_out, valid_out, addr_err
  );
`endif

endinterface

// File: rtl/mem_sp_bytewr_rd_pipe.sv
// Read-response delay line: RD_LATENCY register stages of {valid, err, data}.
// Data stages only load behind a valid beat, so the last stage holds the
// previous read word while valid is low. MEM_PARITY_EN adds a perr bit.
module mem_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef MEM_PARITY_EN
  input  logic                  in_perr,
  output logic                  out_perr,
`endif
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [RD_LATENCY-1:0] v_q;
  logic [RD_LATENCY-1:0] e_q;
  logic [DATA_WIDTH-1:0] d_q [RD_LATENCY];

  // Shift valid/err every cycle; advance data only with a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      e_q <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid;
      e_q[0] <= in_err;
      if (in_valid) d_q[0] <= in_data;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[RD_LATENCY-1];
  assign out_err   = e_q[RD_LATENCY-1];
  assign out_data  = d_q[RD_LATENCY-1];

`ifdef MEM_PARITY_EN
  logic [RD_LATENCY-1:0] p_q;

  // Parity-error flag travels with its read beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q[0] <= in_valid & in_perr;
      for (int i = 1; i < int'(RD_LATENCY); i++) p_q[i] <= p_q[i-1];
    end
  end

  assign out_perr = p_q[RD_LATENCY-1];
`endif

endmodule

// File: rtl/mem_sp_bytewr.sv
// Single-port synchronous RAM with byte-lane writes, configurable read
// latency, out-of-range detection and a zero-fill sweep after every reset.
// Optional feature macro: MEM_PARITY_EN (per-byte even parity + error flag).
module mem_sp_bytewr
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_sp_bytewr_if.slave bus
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reject unsupported configurations at elaboration.
  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
    $error("mem_sp_bytewr: RD_LATENCY must be 1..%0d", MAX_RD_LATENCY);
  end
  if ((DATA_WIDTH % 8) != 0 || ADDR_WIDTH < IDX_W || ADDR_WIDTH > 64 ||
      DEPTH < 2 || DEPTH > 65536) begin : g_bad_geometry
    $error("mem_sp_bytewr: unsupported width/depth combination");
  end

  mem_state_t            state;
  logic [IDX_W-1:0]      ptr;
  logic                  ready_q;

  logic                  accept;
  logic                  rng;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // A request coinciding with a reset edge is dropped.
  assign accept  = bus.en && ready_q && !rst;
  assign rng     = in_range(64'(bus.addr), DEPTH);
  assign idx     = bus.addr[IDX_W-1:0];
  assign rd_acc  = accept && !bus.wr;
  assign wr_acc  = accept && bus.wr && rng;
  assign rd_word = rng ? mem[idx] : '0;

  assign bus.ready = ready_q;

  // Clear FSM: sweep every word once after reset, then serve requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      ptr     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (ptr == IDX_W'(DEPTH - 1)) begin
            state   <= ST_READY;
            ready_q <= 1'b1;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        ST_READY: ready_q <= 1'b1;
        default: begin
          state   <= ST_CLEAR;
          ptr     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage: zero-fill during clear, otherwise byte-lane merge of writes.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (bus.be[i]) mem[idx][8*i +: 8] <= bus.data_in[8*i +: 8];
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic [NUM_LANES-1:0] par_mem [DEPTH];
  logic                 rd_perr;

  // Even-parity bit of each byte lane.
  function automatic logic [NUM_LANES-1:0] lane_par(input logic [DATA_WIDTH-1:0] d);
    logic [NUM_LANES-1:0] p;
    for (int i = 0; i < int'(NUM_LANES); i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  // Parity storage follows the data lanes; inj_par corrupts it on purpose.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      par_mem[ptr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (bus.be[i]) par_mem[idx][i] <= (^bus.data_in[8*i +: 8]) ^ bus.inj_par;
      end
    end
  end

  assign rd_perr = rng && (lane_par(mem[idx]) != par_mem[idx]);
`endif

  mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_err    (accept && !rng),
    .in_data   (rd_word),
`ifdef MEM_PARITY_EN
    .in_perr   (rd_perr),
    .out_perr  (bus.parity_err),
`endif
    .out_valid (bus.valid_out),
    .out_err   (bus.addr_err),
    .out_data  (bus.data_out)
  );

endmodule

// File: tb/tb_mem_sp_bytewr.sv
// Scoreboard bench for mem_sp_bytewr (DEPTH=256, RD_LATENCY=3).
module tb_mem_sp_bytewr;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned RDL   = 3;

  typedef struct {
    int          due;
    logic        valid;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   cnt;
  int   checks;
  int   errors;
  exp_t q[$];
  exp_t m_e;

  mem_sp_bytewr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_sp_bytewr #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RD_LATENCY (RDL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cnt);
    $fatal(1, "watchdog");
  end

  // Monitor: every response beat pops the oldest expectation and is compared.
  always @(negedge clk) begin
    cnt++;
    while (q.size() > 0 && q[0].due < cnt) begin
      checks++;
      errors++;
      $display("FAIL missing_resp actual none at cycle %0d, expected response due at %0d", cnt, q[0].due);
      void'(q.pop_front());
    end
    if (bus.valid_out || bus.addr_err) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp actual valid=%b err=%b data=%h at cycle %0d, expected none",
                 bus.valid_out, bus.addr_err, bus.data_out, cnt);
      end else begin
        m_e = q.pop_front();
        if (cnt != m_e.due || bus.valid_out !== m_e.valid || bus.addr_err !== m_e.err ||
            (m_e.valid && bus.data_out !== m_e.data)) begin
          errors++;
          $display("FAIL resp actual cyc=%0d valid=%b err=%b data=%h, expected cyc=%0d valid=%b err=%b data=%h",
                   cnt, bus.valid_out, bus.addr_err, bus.data_out, m_e.due, m_e.valid, m_e.err, m_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data, input logic exp_err);
    @(negedge clk); #1;
    bus.en = 1'b1; bus.wr = 1'b0; bus.addr = a; bus.be = 4'hF; bus.data_in = 32'hFFFF_FFFF;
    q.push_back('{cnt + int'(RDL), 1'b1, exp_err, exp_data});
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                          input logic exp_err);
    @(negedge clk); #1;
    bus.en = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.be = b; bus.data_in = d;
    if (exp_err) q.push_back('{cnt + int'(RDL), 1'b0, 1'b1, 32'h0});
  endtask

  task automatic idle();
    @(negedge clk); #1;
    bus.en = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  // One-cycle reset; optionally measure the clear window with en held high.
  task automatic do_reset(input bit count, input bit en_during);
    int low;
    bit seen;
    @(negedge clk); #1;
    bus.en = 1'b0; bus.wr = 1'b0; rst = 1'b1;
    q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    if (count) begin
      chk("rst_ready", 32'(bus.ready), 32'h0);
      chk("rst_valid", 32'(bus.valid_out), 32'h0);
      chk("rst_addr_err", 32'(bus.addr_err), 32'h0);
      chk("rst_data_out", bus.data_out, 32'h0);
      low = 0;
      seen = 1'b0;
      bus.en = en_during; bus.wr = 1'b0; bus.addr = 32'd3;
      while (bus.ready !== 1'b1 && low < int'(DEPTH) + 20) begin
        low++;
        if (bus.valid_out || bus.addr_err) seen = 1'b1;
        @(negedge clk); #1;
      end
      bus.en = 1'b0;
      chk("clear_cycles", 32'(low), 32'd256);
      chk("no_resp_in_clear", 32'(seen), 32'h0);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    cnt = 0;
    checks = 0;
    errors = 0;
    bus.en = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.be = '0; bus.data_in = '0;
`ifdef MEM_PARITY_EN
    bus.inj_par = 1'b0;
`endif

    // Reset, clear window, memory reads back zero.
    do_reset(1'b1, 1'b0);
    do_read(32'd0,   32'h0, 1'b0);
    do_read(32'd100, 32'h0, 1'b0);
    do_read(32'd255, 32'h0, 1'b0);
    idle();

    // Full write, read right behind it, partial-lane merge, be=0 no-op.
    do_write(32'd5, 4'hF,    32'hDEAD_BEEF, 1'b0);
    do_read (32'd5, 32'hDEAD_BEEF, 1'b0);
    do_write(32'd5, 4'b0101, 32'h1122_3344, 1'b0);
    do_read (32'd5, 32'hDE22_BE44, 1'b0);
    do_write(32'd5, 4'h0,    32'hFFFF_FFFF, 1'b0);
    do_read (32'd5, 32'hDE22_BE44, 1'b0);
    idle();

    // Eight back-to-back reads after filling words 0..7.
    for (int i = 0; i < 8; i++) do_write(32'(i), 4'hF, 32'hC0DE_0000 + 32'(i) * 32'h0101, 1'b0);
    for (int i = 0; i < 8; i++) do_read(32'(i), 32'hC0DE_0000 + 32'(i) * 32'h0101, 1'b0);
    idle();
    drain();
    chk("data_out_hold", bus.data_out, 32'hC0DE_0707);

    // Out-of-range reads and writes; word 0 untouched.
    do_read (32'd256,       32'h0, 1'b1);
    do_read (32'h8000_0000, 32'h0, 1'b1);
    do_write(32'h8000_0000, 4'hF, 32'hFFFF_FFFF, 1'b1);
    do_write(32'd256,       4'hF, 32'hFFFF_FFFF, 1'b1);
    do_read (32'd0,         32'hC0DE_0000, 1'b0);
    idle();
    drain();
    chk("data_out_hold_after_err", bus.data_out, 32'hC0DE_0000);

    // Reset with two reads in flight; en held high through the clear.
    do_read(32'd0, 32'hC0DE_0000, 1'b0);
    do_read(32'd1, 32'hC0DE_0101, 1'b0);
    do_reset(1'b1, 1'b1);
    do_read(32'd5, 32'h0, 1'b0);
    do_read(32'd7, 32'h0, 1'b0);
    idle();
    drain();

    // Reset in the middle of a clear restarts the full sweep.
    do_write(32'd2, 4'hF, 32'h1234_5678, 1'b0);
    idle();
    do_reset(1'b0, 1'b0);
    repeat (100) @(negedge clk);
    do_reset(1'b1, 1'b0);
    do_read(32'd2, 32'h0, 1'b0);
    idle();
    drain();

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
